// File: rtl/ram_bus_arbiter.sv
// Main-RAM port arbiter: takes the bus from the Z80 via BUSREQ/BUSACK and lends it to
// the CRTC row DMA (master 0, read-only, never preempted) or the PCG/FDC engine (master 1).
module ram_bus_arbiter #(
    parameter int MAX_HOLD1 = 64,
    parameter int ADR_W     = 17
) (
    input  logic             clk,
    input  logic             reset,
    output logic             cpu_busreq,
    input  logic             cpu_busack,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_we,
    input  logic             req0,
    output logic             ack0,
    input  logic [ADR_W-1:0] adr0,
    input  logic             req1,
    output logic             ack1,
    input  logic [ADR_W-1:0] adr1,
    input  logic             we1,
    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_we,
    output logic [1:0]       ram_sel,
    output logic             preempt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT0,
        GRANT1,
        HANDOVER,
        RELEASE
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD1 - 1);

    state_t     state_q, state_d;
    logic       cpu_busreq_q, cpu_busreq_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       preempt_q, preempt_d;
    logic [1:0] ram_sel_q, ram_sel_d;
    logic [7:0] hold_q, hold_d;
    logic       preempt_now;

    // Master 1 is only bumped while master 0 is actually waiting.
    assign preempt_now = (state_q == GRANT1) && req1 && req0 && (hold_q >= HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cpu_busreq_q <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            preempt_q    <= 1'b0;
            ram_sel_q    <= 2'd0;
            hold_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            cpu_busreq_q <= cpu_busreq_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            preempt_q    <= preempt_d;
            ram_sel_q    <= ram_sel_d;
            hold_q       <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) state_d = REQ;
            end
            REQ: begin
                if (cpu_busack) begin
                    if (req0)      state_d = GRANT0;
                    else if (req1) state_d = GRANT1;
                    else           state_d = RELEASE;
                end
            end
            GRANT0: begin
                if (!req0) state_d = req1 ? HANDOVER : RELEASE;
            end
            GRANT1: begin
                if (!req1)            state_d = req0 ? HANDOVER : RELEASE;
                else if (preempt_now) state_d = HANDOVER;
            end
            HANDOVER: begin
                if (req0)      state_d = GRANT0;
                else if (req1) state_d = GRANT1;
                else           state_d = RELEASE;
            end
            RELEASE: begin
                if (!cpu_busack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        cpu_busreq_d = (state_d == REQ) || (state_d == GRANT0) ||
                       (state_d == GRANT1) || (state_d == HANDOVER);
        ack0_d       = (state_d == GRANT0);
        ack1_d       = (state_d == GRANT1);
        preempt_d    = preempt_now;
        ram_sel_d    = 2'd0;
        case (state_d)
            GRANT0:   ram_sel_d = 2'd1;
            GRANT1:   ram_sel_d = 2'd2;
            HANDOVER: ram_sel_d = 2'd3;
            default:  ram_sel_d = 2'd0;
        endcase
        hold_d = 8'd0;
        if ((state_q == GRANT1) && (state_d == GRANT1)) begin
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end
    end

    always_comb begin
        ram_adr = cpu_adr;
        ram_we  = 1'b0;
        case (ram_sel_q)
            2'd0: begin
                ram_adr = cpu_adr;
                ram_we  = cpu_we;
            end
            2'd1: ram_adr = adr0;
            2'd2: begin
                ram_adr = adr1;
                ram_we  = we1;
            end
            default: begin
                ram_adr = cpu_adr;
                ram_we  = 1'b0;
            end
        endcase
    end

    assign cpu_busreq = cpu_busreq_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign preempt    = preempt_q;
    assign ram_sel    = ram_sel_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: hand-derived vector table and corner sequences, then a
// randomized run checked against an ownership-level model of the arbitration rules.
module tb_ram_bus_arbiter;

    localparam int ADR_W     = 17;
    localparam int MAX_HOLD1 = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_busreq;
    logic             cpu_busack;
    logic [ADR_W-1:0] cpu_adr;
    logic             cpu_we;
    logic             req0;
    logic             ack0;
    logic [ADR_W-1:0] adr0;
    logic             req1;
    logic             ack1;
    logic [ADR_W-1:0] adr1;
    logic             we1;
    logic [ADR_W-1:0] ram_adr;
    logic             ram_we;
    logic [1:0]       ram_sel;
    logic             preempt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst, r0, r1, ba, cwe, w1;
        logic       busreq, a0, a1;
        logic [1:0] sel;
        logic       pre, rwe;
    } vec_t;

    vec_t vecs[$];

    // Model of who holds the bus, kept in terms of owners rather than FSM states.
    logic m_busreq  = 1'b0;
    int   m_owner   = 0;
    logic m_handover = 1'b0;
    logic m_drain   = 1'b0;
    int   m_granted = 0;
    logic m_pre     = 1'b0;

    ram_bus_arbiter #(
        .MAX_HOLD1(MAX_HOLD1),
        .ADR_W(ADR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_busreq(cpu_busreq),
        .cpu_busack(cpu_busack),
        .cpu_adr(cpu_adr),
        .cpu_we(cpu_we),
        .req0(req0),
        .ack0(ack0),
        .adr0(adr0),
        .req1(req1),
        .ack1(ack1),
        .adr1(adr1),
        .we1(we1),
        .ram_adr(ram_adr),
        .ram_we(ram_we),
        .ram_sel(ram_sel),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst, r0, r1, ba, cwe, w1);
        @(negedge clk);
        reset      = rst;
        req0       = r0;
        req1       = r1;
        cpu_busack = ba;
        cpu_we     = cwe;
        we1        = w1;
        #1;
    endtask

    task automatic cmp(input string name, input string sig, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s %s: got %0h, expected %0h", name, sig, got, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic eb, ea0, ea1, input logic [1:0] es,
                               input logic ep, ew);
        logic [ADR_W-1:0] ea;
        ea = (es == 2'd1) ? adr0 : (es == 2'd2) ? adr1 : cpu_adr;
        cmp(name, "cpu_busreq", 32'(cpu_busreq), 32'(eb));
        cmp(name, "ack0", 32'(ack0), 32'(ea0));
        cmp(name, "ack1", 32'(ack1), 32'(ea1));
        cmp(name, "ram_sel", 32'(ram_sel), 32'(es));
        cmp(name, "preempt", 32'(preempt), 32'(ep));
        cmp(name, "ram_we", 32'(ram_we), 32'(ew));
        cmp(name, "ram_adr", 32'(ram_adr), 32'(ea));
    endtask

    task automatic step(input string name, input logic rst, r0, r1, ba, cwe, w1,
                        input logic eb, ea0, ea1, input logic [1:0] es, input logic ep, ew);
        applyStimulus(rst, r0, r1, ba, cwe, w1);
        checkOutput(name, eb, ea0, ea1, es, ep, ew);
    endtask

    function automatic void addVec(input logic rst, r0, r1, ba, cwe, w1,
                                   input logic eb, ea0, ea1, input logic [1:0] es, input logic ep, ew);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.ba = ba; v.cwe = cwe; v.w1 = w1;
        v.busreq = eb; v.a0 = ea0; v.a1 = ea1; v.sel = es; v.pre = ep; v.rwe = ew;
        vecs.push_back(v);
    endfunction

    function automatic void modelGrantTo(input logic r0, r1);
        if (r0) begin
            m_owner = 1;
        end else if (r1) begin
            m_owner   = 2;
            m_granted = 0;
        end else begin
            m_busreq = 1'b0;
            m_drain  = 1'b1;
        end
    endfunction

    function automatic void modelFinish(input logic other_waiting);
        m_owner = 0;
        if (other_waiting) begin
            m_handover = 1'b1;
        end else begin
            m_busreq = 1'b0;
            m_drain  = 1'b1;
        end
    endfunction

    function automatic void modelStep(input logic rst, r0, r1, ba);
        m_pre = 1'b0;
        if (rst) begin
            m_busreq = 1'b0; m_owner = 0; m_handover = 1'b0; m_drain = 1'b0; m_granted = 0;
        end else if (m_drain) begin
            if (!ba) m_drain = 1'b0;
        end else if (m_handover) begin
            m_handover = 1'b0;
            modelGrantTo(r0, r1);
        end else if (m_owner == 1) begin
            if (!r0) modelFinish(r1);
        end else if (m_owner == 2) begin
            m_granted++;
            if (!r1) begin
                modelFinish(r0);
            end else if (r0 && m_granted >= MAX_HOLD1) begin
                m_pre      = 1'b1;
                m_owner    = 0;
                m_handover = 1'b1;
            end
        end else if (m_busreq) begin
            if (ba) modelGrantTo(r0, r1);
        end else if (r0 || r1) begin
            m_busreq = 1'b1;
        end
    endfunction

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cpu_busack = 1'b0;
        cpu_we = 1'b0; we1 = 1'b0;
        cpu_adr = 17'h01234; adr0 = 17'h0ABCD; adr1 = 17'h0F300;

        // rst r0 r1 ba cwe we1 | busreq ack0 ack1 sel pre ram_we
        addVec(0,0,0,0,1,0, 0,0,0,2'd0,0,1);
        addVec(0,1,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,1,0,0,0,0, 1,0,0,2'd0,0,0);
        addVec(0,1,0,0,0,0, 1,0,0,2'd0,0,0);
        addVec(0,1,0,1,1,0, 1,0,0,2'd0,0,1);
        addVec(0,1,0,1,1,0, 1,1,0,2'd1,0,0);
        addVec(0,0,0,1,1,0, 1,1,0,2'd1,0,0);
        addVec(0,0,0,1,0,0, 0,0,0,2'd0,0,0);
        addVec(0,1,0,1,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,1,1,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,1,1,1,0,0, 1,0,0,2'd0,0,0);
        addVec(0,0,1,1,0,1, 1,1,0,2'd1,0,0);
        addVec(0,0,1,1,0,1, 1,0,0,2'd3,0,0);
        addVec(0,0,1,1,0,1, 1,0,1,2'd2,0,1);
        addVec(0,0,0,0,0,0, 1,0,1,2'd2,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,1,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 1,0,0,2'd0,0,0);
        addVec(0,0,0,1,0,0, 1,0,0,2'd0,0,0);
        addVec(0,0,0,1,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        addVec(0,0,0,0,0,0, 0,0,0,2'd0,0,0);

        applyStimulus(1,0,0,0,0,0);
        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].ba,
                 vecs[i].cwe, vecs[i].w1, vecs[i].busreq, vecs[i].a0, vecs[i].a1,
                 vecs[i].sel, vecs[i].pre, vecs[i].rwe);
        end

        // Preemption after four grant cycles, then a fresh hold window on regrant.
        step("pre_idle", 0,0,1,0,0,0, 0,0,0,2'd0,0,0);
        step("pre_req",  0,0,1,1,0,1, 1,0,0,2'd0,0,0);
        for (int k = 0; k < 4; k++) step($sformatf("pre_grant%0d", k), 0,1,1,1,0,1, 1,0,1,2'd2,0,1);
        step("pre_handover", 0,1,1,1,0,1, 1,0,0,2'd3,1,0);
        step("pre_m0a", 0,1,1,1,1,1, 1,1,0,2'd1,0,0);
        step("pre_m0b", 0,1,1,1,1,1, 1,1,0,2'd1,0,0);
        step("pre_m0_drop", 0,0,1,1,0,1, 1,1,0,2'd1,0,0);
        step("pre_handover2", 0,0,1,1,0,1, 1,0,0,2'd3,0,0);
        for (int k = 0; k < 4; k++) step($sformatf("pre_regrant%0d", k), 0,1,1,1,0,1, 1,0,1,2'd2,0,1);
        step("pre_handover3", 0,0,0,1,0,0, 1,0,0,2'd3,1,0);
        step("pre_release", 0,0,0,0,0,0, 0,0,0,2'd0,0,0);
        step("pre_done", 0,0,0,0,0,0, 0,0,0,2'd0,0,0);

        // Reset in the middle of a master 1 grant, then a normal master 0 grant.
        step("rst_idle",   0,0,1,0,0,0, 0,0,0,2'd0,0,0);
        step("rst_req",    0,0,1,1,0,0, 1,0,0,2'd0,0,0);
        step("rst_grant",  0,1,1,1,0,0, 1,0,1,2'd2,0,0);
        step("rst_assert", 1,1,1,1,0,0, 1,0,1,2'd2,0,0);
        step("rst_after",  0,1,0,1,0,0, 0,0,0,2'd0,0,0);
        step("rst_req0",   0,1,0,1,0,0, 1,0,0,2'd0,0,0);
        step("rst_grant0", 0,1,0,1,0,0, 1,1,0,2'd1,0,0);
        step("rst_drop",   0,0,0,1,0,0, 1,1,0,2'd1,0,0);
        step("rst_rel",    0,0,0,0,0,0, 0,0,0,2'd0,0,0);

        applyStimulus(1,0,0,0,0,0);
        modelStep(1'b1, 1'b0, 1'b0, 1'b0);
        begin
            logic r0, r1, ba, rst;
            r0 = 1'b0; r1 = 1'b0; ba = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                rst = ($urandom % 300) == 0;
                if (($urandom % 8) == 0) r0 = ~r0;
                if (($urandom % 6) == 0) r1 = ~r1;
                if (m_busreq && !ba && ($urandom % 3) == 0) ba = 1'b1;
                else if (!m_busreq && ba && ($urandom % 3) == 0) ba = 1'b0;
                if (($urandom % 64) == 0) ba = ~ba;
                cpu_adr = 17'($urandom);
                adr0    = 17'($urandom);
                adr1    = 17'($urandom);
                applyStimulus(rst, r0, r1, ba, 1'($urandom), 1'($urandom));
                checkOutput($sformatf("rnd%0d", n), m_busreq, m_owner == 1, m_owner == 2,
                            m_handover ? 2'd3 : 2'(m_owner), m_pre,
                            (m_owner == 2) ? we1 : (m_owner == 0 && !m_handover) ? cpu_we : 1'b0);
                modelStep(rst, r0, r1, ba);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
